mnist_infer_ctrl: RTL

Layer sequencer for the two-layer MNIST MLP. On `start`, it steps one shared MAC datapath through every neuron of the hidden layer, then every neuron of the output layer. It generates operand, weight and bias addresses, the accumulator control strobes and the result-store strobes. While output scores are stored it tracks a running hardware argmax, and it pulses `done` together with the predicted digit.

---
 rtl/mnist_infer_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mnist_infer_ctrl.sv
// Layer sequencer for a two-layer MLP: walks one shared MAC datapath through every
// hidden neuron, then every output neuron, and tracks the argmax of the output scores.
module mnist_infer_ctrl #(
    parameter int IN_N  = 784,
    parameter int HID_N = 32,
    parameter int OUT_N = 10,
    parameter int DW    = 16,
    localparam int AW   = $clog2(HID_N*IN_N + OUT_N*HID_N),
    localparam int IAW  = $clog2((IN_N > HID_N) ? IN_N : HID_N),
    localparam int BW   = $clog2(HID_N + OUT_N),
    localparam int SW   = $clog2((HID_N > OUT_N) ? HID_N : OUT_N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [3:0]     pred_digit,
    output logic           layer,
    output logic [IAW-1:0] in_addr,
    output logic [AW-1:0]  w_addr,
    output logic [BW-1:0]  b_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           bias_en,
    output logic           st_we,
    output logic [SW-1:0]  st_addr,
    output logic           relu_en,
    input  logic [DW-1:0]  acc_q
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_MAC, S_DRAIN, S_BIAS, S_STORE, S_DONE
    } state_t;

    localparam logic [IAW-1:0] IN_LAST  = IAW'(IN_N - 1);
    localparam logic [IAW-1:0] HID_TAP  = IAW'(HID_N - 1);
    localparam logic [SW-1:0]  HID_LAST = SW'(HID_N - 1);
    localparam logic [SW-1:0]  OUT_LAST = SW'(OUT_N - 1);
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    state_t state, state_d;

    logic [IAW-1:0] k;
    logic [SW-1:0]  n;
    logic [AW-1:0]  w_ptr;
    logic [BW-1:0]  b_ptr;
    logic signed [DW-1:0] max_q;
    logic [3:0]     idx_q;

    logic last_tap;
    logic last_n;
    logic score_win;

    assign last_tap  = (k == (layer ? HID_TAP : IN_LAST));
    assign last_n    = (n == (layer ? OUT_LAST : HID_LAST));
    assign score_win = layer && ($signed(acc_q) > max_q);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_MAC;
            S_MAC:   if (last_tap) state_d = S_DRAIN;
            S_DRAIN: state_d = S_BIAS;
            S_BIAS:  state_d = S_STORE;
            S_STORE: state_d = (layer && last_n) ? S_DONE : S_CLR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weights and biases are laid out contiguously neuron after neuron, hidden layer
    // first, so both address pointers simply advance across the whole inference.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            n          <= '0;
            layer      <= 1'b0;
            w_ptr      <= '0;
            b_ptr      <= '0;
            mac_en     <= 1'b0;
            max_q      <= '0;
            idx_q      <= '0;
            pred_digit <= '0;
        end else begin
            // Memories answer one cycle after the address, so the accumulate strobe lags MAC.
            mac_en <= (state == S_MAC);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        layer <= 1'b0;
                        n     <= '0;
                        w_ptr <= '0;
                        b_ptr <= '0;
                        max_q <= MOST_NEG;
                        idx_q <= '0;
                    end
                end
                S_CLR: k <= '0;
                S_MAC: begin
                    k     <= k + IAW'(1);
                    w_ptr <= w_ptr + AW'(1);
                end
                S_STORE: begin
                    b_ptr <= b_ptr + BW'(1);
                    if (score_win) begin
                        max_q <= $signed(acc_q);
                        idx_q <= 4'(n);
                    end
                    if (layer && last_n)
                        pred_digit <= score_win ? 4'(n) : idx_q;
                    if (last_n) begin
                        n     <= '0;
                        layer <= 1'b1;
                    end else begin
                        n <= n + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        in_addr = '0;
        w_addr  = '0;
        b_addr  = '0;
        mac_clr = 1'b0;
        bias_en = 1'b0;
        st_we   = 1'b0;
        st_addr = '0;
        relu_en = 1'b0;
        if (state inside {S_CLR, S_MAC, S_DRAIN, S_BIAS, S_STORE}) begin
            busy   = 1'b1;
            b_addr = b_ptr;
        end
        case (state)
            S_CLR: mac_clr = 1'b1;
            S_MAC: begin
                in_addr = k;
                w_addr  = w_ptr;
            end
            S_BIAS: bias_en = 1'b1;
            S_STORE: begin
                st_we   = 1'b1;
                st_addr = n;
                relu_en = ~layer;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
